spread_history: RTL and testbench
=================================

Name: spread_history

Overview:
- Downstream consumer of the spread stage.
- Captures each updated spread value into a circular history buffer and keeps lifetime min, max and last statistics.
- Serves a random-access read port for the VGA analytics plotter.
- Sits between the spread register and the VGA chart renderer.

Parameters:
- WIDTH, 8, bit width of one spread sample (matches spread output).
- DEPTH, 64, number of history entries; must be a power of two, ≥ 2.
- AW, $clog2(DEPTH), address width (derived, do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe: spread_in holds a new value (driven from enable_count & match_siganl, registered to align with spread).
- spread_in  input  WIDTH  spread value, unsigned.
- clear  input  1  synchronous clear of history and statistics.
- rd_en  input  1  read request.
- rd_addr  input  AW  age of requested entry; 0 = newest.
- rd_data  output  WIDTH  read result, valid the cycle after rd_en.
- rd_valid  output  1  high one cycle after rd_en.
- rd_hit  output  1  with rd_valid: requested entry exists (rd_addr < count).
- count  output  AW+1  stored entries, saturates at DEPTH.
- full  output  1  count == DEPTH.
- last_spread  output  WIDTH  most recent sample.
- min_spread  output  WIDTH  minimum since reset/clear.
- max_spread  output  WIDTH  maximum since reset/clear.

Behaviour:
- Reset (resetn=0, async): wr_ptr=0, count=0, full=0, last/max=0, min=all-ones, rd_data=0, rd_valid=0, rd_hit=0, buffer contents zeroed.
- Assertion mid-operation aborts any pending read; rd_valid drops immediately.
- Write, on sample_valid=1 at posedge clk:
  - mem[wr_ptr] <= spread_in.
  - wr_ptr <= wr_ptr+1, modulo DEPTH.
  - count increments, saturating at DEPTH.
  - last_spread <= spread_in.
- Full buffer: writes overwrite the oldest entry; no stall, no overflow flag.
- Statistics:
  - min/max compare unsigned; wrapped values (e.g. 244 from 60-72) are treated as large positives.
  - Updated the same edge as the write, so visible 1 cycle after sample_valid.
  - A min/max tie keeps the value (no change).
- Read:
  - On rd_en, the physical index is (wr_ptr - 1 - rd_addr) mod DEPTH, using wr_ptr and count sampled in that cycle.
  - Next cycle: rd_valid=1; rd_data = entry if rd_addr < count, else 0 with rd_hit=0.
  - Fixed latency 1. No back-pressure; rd_en may be asserted every cycle.
- Simultaneous write and read in one cycle: the read sees pre-write state (rd_addr 0 returns the previous newest).
- clear=1 at posedge:
  - Same effect as reset on wr_ptr, count, full and statistics.
  - Buffer RAM is not zeroed; count=0 makes stale data unreachable.
  - Read outputs are unaffected that cycle.
- clear and sample_valid in the same cycle: clear wins and the sample is dropped.
- clear and rd_en in the same cycle: the read uses pre-clear state.
- No FSM beyond the pointer/count registers; all outputs are registered.

Optional Feature:
- Macro: SPREAD_HISTORY_AVG_EN.
- Defined:
  - Adds outputs avg_spread[WIDTH-1:0] and avg_valid.
  - A running sum of width WIDTH+AW is kept over the window.
  - On each write: sum <= sum + spread_in - (full ? mem[wr_ptr] : 0).
  - avg_spread = sum >> AW, registered.
  - avg_valid = full.
  - clear/reset zero the sum.
- Undefined: the ports and sum register are absent; all other behaviour is unchanged.

Decomposition:
- Shared package spread_pkg holds:
  - SPREAD_W=8.
  - Default HIST_DEPTH=64.
  - Unsigned spread typedef spread_t.
  - Constant SPREAD_MIN_INIT (all ones).
- One natural sub-module: spread_hist_ram, a simple dual-port (1W/1R) registered-read memory, DEPTH x WIDTH, with async reset of the read register.
- Pointer, count and statistics logic stays in the top module.

Test Plan (DEPTH=4 override unless noted):
- Reset then samples 4,5,244,26 → count=4, full=1, last=26, min=4, max=244; reads at rd_addr 0..3 return 26,244,5,4 with rd_valid one cycle later.
- Two samples 10,20, then read rd_addr=3 → rd_valid=1, rd_hit=0, rd_data=0; rd_addr=1 → 10 with rd_hit=1.
- Fill with 1,2,3,4, then write 9 → count stays 4; rd_addr 0..3 = 9,4,3,2; min stays 1 (lifetime).
- Same cycle sample_valid=1 (value 7) and rd_en rd_addr=0 after newest=4 → rd_data=4; next read rd_addr=0 → 7. Same cycle clear + sample 50 → count=0, last=0, min=255, max=0.
- Deassert resetn mid-stream with rd_en active → all outputs zero asynchronously, min=255; after release, first sample 3 gives count=1 and min=max=last=3.
- With SPREAD_HISTORY_AVG_EN: samples 4,8,12,16 → avg_valid=1, avg=10; then sample 20 → avg=14.

Source files
------------

// File: rtl/spread_pkg.sv
// Shared definitions for the spread history block: default sample width,
// default history depth, the spread sample type and the reset value used
// for the running minimum.
package spread_pkg;

  // Width of one spread sample, matching the spread stage output.
  localparam int SPREAD_W   = 8;

  // Default number of history entries (power of two).
  localparam int HIST_DEPTH = 64;

  // Unsigned spread sample.
  typedef logic [SPREAD_W-1:0] spread_t;

  // Minimum tracker starts at all ones so the first sample always replaces it.
  localparam spread_t SPREAD_MIN_INIT = {SPREAD_W{1'b1}};

  // Physical slot holding the entry that is `age` samples older than the
  // newest one. The newest entry sits one slot behind the write pointer.
  // depth must be a power of two, so the wrap is a simple mask.
  function automatic logic [31:0] age_to_index(
    input logic [31:0] wr_ptr,
    input logic [31:0] age,
    input logic [31:0] depth
  );
    return (wr_ptr - 32'd1 - age) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/spread_hist_ram.sv
// Simple dual-port history memory: one write port, one registered read port.
// The array and the read register are both cleared by the asynchronous reset.
// A read that targets a non-existent entry (rd_hit_i low) loads zero.
// Optional macro SPREAD_HISTORY_AVG_EN adds a combinational peek of the slot
// about to be overwritten, used by the running-sum logic in the top.
module spread_hist_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             rd_hit_i,
  input  logic [AW-1:0]    rd_addr_i,
`ifdef SPREAD_HISTORY_AVG_EN
  output logic [WIDTH-1:0] ow_data_o,
`endif
  output logic [WIDTH-1:0] rd_data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            rd_data_q;

  // Storage array: zeroed on reset, one entry written per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: captures the addressed entry (pre-write contents) or zero
  // for a miss; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else if (rd_en_i) begin
      if (rd_hit_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end else begin
        rd_data_q <= {WIDTH{1'b0}};
      end
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef SPREAD_HISTORY_AVG_EN
  // Oldest entry, which the next write will replace once the window is full.
  assign ow_data_o = mem_q[wr_addr_i];
`endif

endmodule

// File: rtl/spread_history.sv
// spread_history: circular history of spread samples with lifetime
// min/max/last statistics and a fixed-latency random-access read port for
// the chart renderer. Read address is an age (0 = newest).
// Optional macro SPREAD_HISTORY_AVG_EN adds a windowed running average
// (avg_spread, avg_valid).
module spread_history
  import spread_pkg::*;
#(
  parameter int WIDTH = SPREAD_W,
  parameter int DEPTH = HIST_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] spread_in,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [AW:0]      count,
  output logic             full,
  output logic [WIDTH-1:0] last_spread,
  output logic [WIDTH-1:0] min_spread,
  output logic [WIDTH-1:0] max_spread
`ifdef SPREAD_HISTORY_AVG_EN
  ,
  output logic [WIDTH-1:0] avg_spread,
  output logic             avg_valid
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Pointer, occupancy and statistics state.
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             full_q;
  logic [WIDTH-1:0] last_q,   last_d;
  logic [WIDTH-1:0] min_q,    min_d;
  logic [WIDTH-1:0] max_q,    max_d;
  logic             rd_valid_q;
  logic             rd_hit_q;

  // Combinational helpers.
  logic             wr_s;
  logic [AW-1:0]    rd_idx_s;
  logic             rd_hit_s;
  logic [WIDTH-1:0] ram_rd_data_s;

  // Write qualification and read address translation, all on pre-edge state.
  always_comb begin
    // clear takes priority: a sample arriving with clear is dropped
    wr_s     = sample_valid & ~clear;
    rd_idx_s = AW'(age_to_index(32'(wr_ptr_q), 32'(rd_addr), 32'(DEPTH)));
    rd_hit_s = ({1'b0, rd_addr} < count_q);
  end

  // Next-state for pointer, occupancy and lifetime statistics.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    min_d    = min_q;
    max_d    = max_q;
    if (clear) begin
      wr_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
      last_d   = {WIDTH{1'b0}};
      min_d    = {WIDTH{1'b1}};
      max_d    = {WIDTH{1'b0}};
    end else if (sample_valid) begin
      // pointer wraps naturally because DEPTH is a power of two
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
      // once full, new samples overwrite the oldest; occupancy saturates
      if (count_q != DEPTH_C) begin
        count_d = count_q + (AW+1)'(1'b1);
      end else begin
        count_d = count_q;
      end
      last_d = spread_in;
      // unsigned compares; ties leave the tracked value untouched
      if (spread_in < min_q) begin
        min_d = spread_in;
      end else begin
        min_d = min_q;
      end
      if (spread_in > max_q) begin
        max_d = spread_in;
      end else begin
        max_d = max_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end
  end

  // State registers for pointer, occupancy, full flag and statistics.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      last_q   <= {WIDTH{1'b0}};
      min_q    <= {WIDTH{1'b1}};
      max_q    <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      last_q   <= last_d;
      min_q    <= min_d;
      max_q    <= max_d;
    end
  end

  // Read handshake flags: one-cycle latency, untouched by clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en & rd_hit_s;
    end
  end

`ifdef SPREAD_HISTORY_AVG_EN
  logic [WIDTH+AW-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]    avg_q;
  logic [WIDTH-1:0]    ow_data_s;

  // Running window sum: add the new sample, retire the overwritten one.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = {(WIDTH+AW){1'b0}};
    end else if (sample_valid) begin
      if (full_q) begin
        sum_d = sum_q + (WIDTH+AW)'(spread_in) - (WIDTH+AW)'(ow_data_s);
      end else begin
        sum_d = sum_q + (WIDTH+AW)'(spread_in);
      end
    end else begin
      sum_d = sum_q;
    end
  end

  // Sum and average registers; average is the window sum divided by DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q <= {(WIDTH+AW){1'b0}};
      avg_q <= {WIDTH{1'b0}};
    end else begin
      sum_q <= sum_d;
      avg_q <= sum_d[WIDTH+AW-1:AW];
    end
  end

  assign avg_spread = avg_q;
  assign avg_valid  = full_q;
`endif

  spread_hist_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (resetn),
    .wr_en_i   (wr_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (spread_in),
    .rd_en_i   (rd_en),
    .rd_hit_i  (rd_hit_s),
    .rd_addr_i (rd_idx_s),
`ifdef SPREAD_HISTORY_AVG_EN
    .ow_data_o (ow_data_s),
`endif
    .rd_data_o (ram_rd_data_s)
  );

  assign rd_data     = ram_rd_data_s;
  assign rd_valid    = rd_valid_q;
  assign rd_hit      = rd_hit_q;
  assign count       = count_q;
  assign full        = full_q;
  assign last_spread = last_q;
  assign min_spread  = min_q;
  assign max_spread  = max_q;

endmodule

// File: tb/tb_spread_history.sv
// Self-checking bench for spread_history with DEPTH=4. A queue-based model
// holds the visible window (newest at the back) and lifetime statistics.
// Optional macro SPREAD_HISTORY_AVG_EN enables the running-average checks.
module tb_spread_history;
  import spread_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int A = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] spread_in = 8'd0;
  logic         clear = 1'b0;
  logic         rd_en = 1'b0;
  logic [A-1:0] rd_addr = 2'd0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_hit;
  logic [A:0]   count;
  logic         full;
  logic [W-1:0] last_spread;
  logic [W-1:0] min_spread;
  logic [W-1:0] max_spread;
`ifdef SPREAD_HISTORY_AVG_EN
  logic [W-1:0] avg_spread;
  logic         avg_valid;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int           hist[$];
  int           m_min;
  int           m_max;
  int           m_last;
  logic [W-1:0] e_rd_data;
  logic         e_rd_valid;
  logic         e_rd_hit;

  spread_history #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .spread_in    (spread_in),
    .clear        (clear),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_hit       (rd_hit),
    .count        (count),
    .full         (full),
    .last_spread  (last_spread),
    .min_spread   (min_spread),
`ifdef SPREAD_HISTORY_AVG_EN
    .avg_spread   (avg_spread),
    .avg_valid    (avg_valid),
`endif
    .max_spread   (max_spread)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_min      = int'(SPREAD_MIN_INIT);
    m_max      = 0;
    m_last     = 0;
    e_rd_data  = 8'd0;
    e_rd_valid = 1'b0;
    e_rd_hit   = 1'b0;
  endtask

  // Apply one cycle of inputs, let the edge pass, sample at edge+1 and
  // advance the model. Reads are resolved against the pre-edge window.
  task automatic step(input logic sv, input int val, input logic clr,
                      input logic ren, input int ra);
    sample_valid = sv;
    spread_in    = 8'(val);
    clear        = clr;
    rd_en        = ren;
    rd_addr      = 2'(ra);
    @(posedge clk);
    #1;
    e_rd_valid = ren;
    if (ren) begin
      if (ra < hist.size()) begin
        e_rd_hit  = 1'b1;
        e_rd_data = 8'(hist[hist.size() - 1 - ra]);
      end else begin
        e_rd_hit  = 1'b0;
        e_rd_data = 8'd0;
      end
    end else begin
      e_rd_hit = 1'b0;
    end
    if (clr) begin
      hist.delete();
      m_min  = 255;
      m_max  = 0;
      m_last = 0;
    end else if (sv) begin
      hist.push_back(val);
      if (hist.size() > D) void'(hist.pop_front());
      if (val < m_min) m_min = val;
      if (val > m_max) m_max = val;
      m_last = val;
    end
    sample_valid = 1'b0;
    clear        = 1'b0;
    rd_en        = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (last_spread !== 8'd0) begin errors++; $display("FAIL reset_last: got %0d expected 0", last_spread); end
    checks++; if (min_spread !== 8'd255) begin errors++; $display("FAIL reset_min: got %0d expected 255", min_spread); end
    checks++; if (max_spread !== 8'd0) begin errors++; $display("FAIL reset_max: got %0d expected 0", max_spread); end
    checks++; if ({rd_valid, rd_hit, rd_data} !== 10'd0) begin errors++; $display("FAIL reset_read: got v=%0b h=%0b d=%0d expected all 0", rd_valid, rd_hit, rd_data); end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_read();
    int vals[4] = '{4, 5, 244, 26};
    int expd[4] = '{26, 244, 5, 4};
    step(1'b0, 0, 1'b1, 1'b0, 0);
    foreach (vals[i]) step(1'b1, vals[i], 1'b0, 1'b0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
    checks++; if (last_spread !== 8'd26) begin errors++; $display("FAIL fill_last: got %0d expected 26", last_spread); end
    checks++; if (min_spread !== 8'd4) begin errors++; $display("FAIL fill_min: got %0d expected 4", min_spread); end
    checks++; if (max_spread !== 8'd244) begin errors++; $display("FAIL fill_max: got %0d expected 244", max_spread); end
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 0, 1'b0, 1'b1, a);
      checks++;
      if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 8'(expd[a])) begin
        errors++; $display("FAIL fill_read%0d: got v=%0b h=%0b d=%0d expected v=1 h=1 d=%0d", a, rd_valid, rd_hit, rd_data, expd[a]);
      end
    end
    step(1'b0, 0, 1'b0, 1'b0, 0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_drop: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_partial_read();
    step(1'b0, 0, 1'b1, 1'b0, 0);
    step(1'b1, 10, 1'b0, 1'b0, 0);
    step(1'b1, 20, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1'b0, 1'b1, 3);
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b0 || rd_data !== 8'd0) begin errors++; $display("FAIL miss_read: got v=%0b h=%0b d=%0d expected v=1 h=0 d=0", rd_valid, rd_hit, rd_data); end
    step(1'b0, 0, 1'b0, 1'b1, 1);
    checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 8'd10) begin errors++; $display("FAIL hit_read: got v=%0b h=%0b d=%0d expected v=1 h=1 d=10", rd_valid, rd_hit, rd_data); end
  endtask

  task automatic test_wrap();
    int expd[4] = '{9, 4, 3, 2};
    step(1'b0, 0, 1'b1, 1'b0, 0);
    for (int v = 1; v <= 4; v++) step(1'b1, v, 1'b0, 1'b0, 0);
    step(1'b1, 9, 1'b0, 1'b0, 0);
    checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL wrap_count: got %0d/%0b expected 4/1", count, full); end
    checks++; if (min_spread !== 8'd1) begin errors++; $display("FAIL wrap_min: got %0d expected 1", min_spread); end
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 0, 1'b0, 1'b1, a);
      checks++;
      if (rd_hit !== 1'b1 || rd_data !== 8'(expd[a])) begin
        errors++; $display("FAIL wrap_read%0d: got h=%0b d=%0d expected h=1 d=%0d", a, rd_hit, rd_data, expd[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 0, 1'b1, 1'b0, 0);
    step(1'b1, 1, 1'b0, 1'b0, 0);
    step(1'b1, 4, 1'b0, 1'b0, 0);
    step(1'b1, 7, 1'b0, 1'b1, 0);
    checks++; if (rd_data !== 8'd4) begin errors++; $display("FAIL rw_same_cycle: got %0d expected 4", rd_data); end
    step(1'b0, 0, 1'b0, 1'b1, 0);
    checks++; if (rd_data !== 8'd7) begin errors++; $display("FAIL rw_next_read: got %0d expected 7", rd_data); end
    step(1'b1, 50, 1'b1, 1'b0, 0);
    checks++; if (count !== 3'd0 || last_spread !== 8'd0) begin errors++; $display("FAIL clear_wins: got count=%0d last=%0d expected 0/0", count, last_spread); end
    checks++; if (min_spread !== 8'd255 || max_spread !== 8'd0) begin errors++; $display("FAIL clear_stats: got min=%0d max=%0d expected 255/0", min_spread, max_spread); end
    step(1'b1, 8, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b1, 0);
    checks++; if (rd_hit !== 1'b1 || rd_data !== 8'd8 || count !== 3'd0) begin errors++; $display("FAIL clear_read: got h=%0b d=%0d count=%0d expected h=1 d=8 count=0", rd_hit, rd_data, count); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 11, 1'b0, 1'b1, 0);
    step(1'b1, 12, 1'b0, 1'b1, 0);
    sample_valid = 1'b1;
    spread_in    = 8'd13;
    rd_en        = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_data !== 8'd0) begin errors++; $display("FAIL areset_read: got v=%0b h=%0b d=%0d expected all 0", rd_valid, rd_hit, rd_data); end
    checks++; if (count !== 3'd0 || full !== 1'b0 || last_spread !== 8'd0 || max_spread !== 8'd0) begin errors++; $display("FAIL areset_state: got count=%0d full=%0b last=%0d max=%0d expected zeros", count, full, last_spread, max_spread); end
    checks++; if (min_spread !== 8'd255) begin errors++; $display("FAIL areset_min: got %0d expected 255", min_spread); end
    sample_valid = 1'b0;
    rd_en        = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 3, 1'b0, 1'b0, 0);
    checks++; if (count !== 3'd1 || min_spread !== 8'd3 || max_spread !== 8'd3 || last_spread !== 8'd3) begin errors++; $display("FAIL areset_first: got count=%0d min=%0d max=%0d last=%0d expected 1/3/3/3", count, min_spread, max_spread, last_spread); end
  endtask

`ifdef SPREAD_HISTORY_AVG_EN
  task automatic test_avg();
    step(1'b0, 0, 1'b1, 1'b0, 0);
    for (int v = 4; v <= 16; v += 4) step(1'b1, v, 1'b0, 1'b0, 0);
    checks++; if (avg_valid !== 1'b1 || avg_spread !== 8'd10) begin errors++; $display("FAIL avg_full: got v=%0b avg=%0d expected 1/10", avg_valid, avg_spread); end
    step(1'b1, 20, 1'b0, 1'b0, 0);
    checks++; if (avg_spread !== 8'd14) begin errors++; $display("FAIL avg_slide: got %0d expected 14", avg_spread); end
  endtask
`endif

  task automatic test_random();
    int sum;
    step(1'b0, 0, 1'b1, 1'b0, 0);
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
      checks++; if (count !== 3'(hist.size()) || full !== (hist.size() == D)) begin errors++; $display("FAIL rand_count[%0d]: got %0d/%0b expected %0d", n, count, full, hist.size()); end
      checks++; if (last_spread !== 8'(m_last) || min_spread !== 8'(m_min) || max_spread !== 8'(m_max)) begin errors++; $display("FAIL rand_stats[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", n, last_spread, min_spread, max_spread, m_last, m_min, m_max); end
      checks++; if (rd_valid !== e_rd_valid || rd_hit !== e_rd_hit || rd_data !== e_rd_data) begin errors++; $display("FAIL rand_read[%0d]: got v=%0b h=%0b d=%0d expected v=%0b h=%0b d=%0d", n, rd_valid, rd_hit, rd_data, e_rd_valid, e_rd_hit, e_rd_data); end
`ifdef SPREAD_HISTORY_AVG_EN
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      checks++; if (avg_spread !== 8'(sum >> A) || avg_valid !== (hist.size() == D)) begin errors++; $display("FAIL rand_avg[%0d]: got %0d/%0b expected %0d", n, avg_spread, avg_valid, sum >> A); end
`else
      sum = 0;
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_read();
    test_partial_read();
    test_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef SPREAD_HISTORY_AVG_EN
    test_avg();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
